// File: rtl/divider_pkg.sv
// Shared definitions for the shift/add-subtract divider.
// Controller and datapath agree on the sel encoding here.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'b00,
    SEL_ALU    = 2'b01,
    SEL_IDLE   = 2'b10,
    SEL_COMMIT = 2'b11
  } sel_e;

endpackage

// File: rtl/divider_datapath_if.sv
// Result handshake between the divider datapath and its consumer.
// master drives the result, slave accepts it with out_ready.
interface divider_datapath_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output quotient,
    output remainder,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  quotient,
    input  remainder,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/divider_addsub.sv
// Combinational adder/subtractor, modulo 2^W.
// Used for the iteration step and the final restore.
module divider_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         add,
  output logic [W-1:0] sum
);

  assign sum = add ? (a + b) : (a - b);

endmodule

// File: rtl/divider_datapath.sv
// Divider datapath: D/Q/R working registers plus result register.
// Optional DIVIDER_DIV_ZERO_DETECT_EN adds dz and zero-forced results.
module divider_datapath
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             load,
  input  logic [1:0]       sel,
  input  logic             shift,
  input  logic             inbit,
  input  logic             add,
  output logic             sign,
  output logic             overrun,
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
  output logic             dz,
`endif
  divider_datapath_if.master res
);

  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   alu_a;
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH:0]   fix_sum;
  logic             fix_unused;
  logic             commit;
  logic             force_zero;

  assign r_sh       = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign alu_a      = shift ? r_sh : r_q;
  assign commit     = !load && (sel == SEL_COMMIT);
  assign fix_unused = fix_sum[WIDTH];

  divider_addsub #(.W(WIDTH+1)) u_alu (
    .a   (alu_a),
    .b   ({1'b0, d_q}),
    .add (add),
    .sum (alu_sum)
  );

  divider_addsub #(.W(WIDTH+1)) u_fix (
    .a   (r_q),
    .b   ({1'b0, d_q}),
    .add (1'b1),
    .sum (fix_sum)
  );

`ifdef DIVIDER_DIV_ZERO_DETECT_EN
  logic dz_q, dz_d;

  assign dz_d       = load ? (divisor == '0) : dz_q;
  assign force_zero = dz_q;
  assign dz         = dz_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dz_q <= 1'b0;
    else        dz_q <= dz_d;
  end
`else
  assign force_zero = 1'b0;
`endif

  always_comb begin
    d_d = d_q;
    q_d = q_q;
    r_d = r_q;
    if (load) begin
      d_d = divisor;
      q_d = dividend;
      r_d = '0;
    end else begin
      if (shift) q_d = {q_q[WIDTH-2:0], inbit};
      if (sel == SEL_ALU) r_d = alu_sum;
      else if (shift)     r_d = r_sh;
    end
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (commit) begin
      quo_d = q_q;
      rem_d = r_q[WIDTH] ? fix_sum[WIDTH-1:0] : r_q[WIDTH-1:0];
      if (force_zero) begin
        quo_d = '0;
        rem_d = '0;
      end
      vld_d = 1'b1;
      // overwriting an unaccepted result is sticky until reset
      if (vld_q && !res.out_ready) ovr_d = 1'b1;
    end else if (res.out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      q_q   <= q_d;
      r_q   <= r_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

  assign sign          = r_q[WIDTH];
  assign overrun       = ovr_q;
  assign res.quotient  = quo_q;
  assign res.remainder = rem_q;
  assign res.out_valid = vld_q;

endmodule

// File: tb/tb_divider_datapath.sv
// Scoreboard bench for divider_datapath, oracle-driven control sequences.
// Build with +define+DIVIDER_DIV_ZERO_DETECT_EN to cover dz.
module tb_divider_datapath;
  import divider_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dividend, divisor;
  logic         load, shift, inbit, add;
  logic [1:0]   sel;
  logic         sign, overrun;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
  logic         dz;
`endif

  divider_datapath_if #(.WIDTH(W)) res_if ();

  divider_datapath #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .dividend (dividend),
    .divisor  (divisor),
    .load     (load),
    .sel      (sel),
    .shift    (shift),
    .inbit    (inbit),
    .add      (add),
    .sign     (sign),
    .overrun  (overrun),
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
    .dz       (dz),
`endif
    .res      (res_if.master)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load  = 1'b0;
    sel   = 2'b00;
    shift = 1'b0;
    inbit = 1'b0;
    add   = 1'b0;
  endtask

  // plain integer division; divide by zero yields all-ones / dividend
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic res_t expected(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    ref_div(a, b, e.q, e.r);
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
    if (b == 0) begin
      e.q = '0;
      e.r = '0;
    end
`endif
    return e;
  endfunction

  task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
    idle();
    dividend = a;
    divisor  = b;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic run_restoring(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    logic qb;
    do_load(a, b);
    ref_div(a, b, q, r);
    for (int i = 0; i < W; i++) begin
      qb = q[W-1-i];
      sel = SEL_HOLD; shift = 1'b1; inbit = qb;
      step();
      sel = SEL_ALU; shift = 1'b0; add = 1'b0;
      step();
      chk("rs_sign", sign, !qb);
      if (!qb) begin
        add = 1'b1;
        step();
      end
    end
    idle();
  endtask

  task automatic run_nonrestoring(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    logic qb, neg;
    do_load(a, b);
    ref_div(a, b, q, r);
    neg = 1'b0;
    for (int i = 0; i < W; i++) begin
      qb = q[W-1-i];
      sel = SEL_ALU; shift = 1'b1; add = neg; inbit = qb;
      step();
      chk("nr_sign", sign, !qb);
      neg = !qb;
    end
    idle();
  endtask

  task automatic commit_push(input res_t e);
    exp_q.push_back(e);
    sel = SEL_COMMIT;
    step();
    sel = SEL_HOLD;
  endtask

  // monitor: a commit edge must present the next expected result
  always @(posedge clk) begin
    if (reset && !load && sel == 2'b11) begin
      res_t e;
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected actual=commit required=none");
      end else begin
        e = exp_q.pop_front();
        chk("mon_valid", res_if.out_valid, 1'b1);
        chk("mon_quotient", res_if.quotient, e.q);
        chk("mon_remainder", res_if.remainder, e.r);
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    res_t e;

    reset = 1'b0;
    res_if.out_ready = 1'b0;
    dividend = '0; divisor = '0;
    idle();
    for (int i = 0; i < 3; i++) begin
      dividend = W'($urandom); divisor = W'($urandom);
      load = 1'($urandom); sel = 2'($urandom);
      shift = 1'($urandom); inbit = 1'($urandom); add = 1'($urandom);
      res_if.out_ready = 1'($urandom);
      step();
    end
    chk("rst_valid", res_if.out_valid, 1'b0);
    chk("rst_sign", sign, 1'b0);
    idle();
    res_if.out_ready = 1'b1;
    reset = 1'b1;
    step();
    chk("rel_sign", sign, 1'b0);
    chk("rel_valid", res_if.out_valid, 1'b0);
    chk("rel_overrun", overrun, 1'b0);
    chk("rel_quotient", res_if.quotient, '0);
    chk("rel_remainder", res_if.remainder, '0);

    run_restoring(8'd100, 8'd7);
    e.q = 8'd14; e.r = 8'd2;
    commit_push(e);
    step();
    chk("accept_clear", res_if.out_valid, 1'b0);

    do_load(8'd5, 8'd3);
    sel = SEL_ALU; shift = 1'b1; add = 1'b0;
    step();
    chk("comb_sub_sign", sign, 1'b1);
    shift = 1'b0; add = 1'b1;
    step();
    chk("comb_add_sign", sign, 1'b0);
    idle();

    dividend = 8'd5; divisor = 8'd3;
    load = 1'b1; sel = SEL_ALU; shift = 1'b1; add = 1'b0;
    step();
    idle();
    chk("load_prio_sign", sign, 1'b0);
    e.q = 8'd5; e.r = 8'd0;
    commit_push(e);
    step();

    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
      if (i % 2 == 0) run_restoring(a, b);
      else            run_nonrestoring(a, b);
      commit_push(expected(a, b));
      step();
    end
    chk("rand_no_overrun", overrun, 1'b0);

    res_if.out_ready = 1'b0;
    run_restoring(8'd100, 8'd7);
    commit_push(expected(8'd100, 8'd7));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", res_if.out_valid, 1'b1);
    end
    chk("pre_overrun", overrun, 1'b0);
    run_nonrestoring(8'd9, 8'd2);
    commit_push(expected(8'd9, 8'd2));
    chk("overrun_set", overrun, 1'b1);
    res_if.out_ready = 1'b1;
    step();
    chk("ready_clear", res_if.out_valid, 1'b0);
    chk("overrun_sticky", overrun, 1'b1);

    res_if.out_ready = 1'b0;
    run_restoring(8'd77, 8'd5);
    commit_push(expected(8'd77, 8'd5));
    run_nonrestoring(8'd200, 8'd13);
    res_if.out_ready = 1'b1;
    commit_push(expected(8'd200, 8'd13));
    step();
    chk("simul_then_clear", res_if.out_valid, 1'b0);

`ifdef DIVIDER_DIV_ZERO_DETECT_EN
    do_load(8'd200, 8'd0);
    chk("dz_set", dz, 1'b1);
    commit_push(expected(8'd200, 8'd0));
    step();
    do_load(8'd10, 8'd3);
    chk("dz_clear", dz, 1'b0);
`endif

    res_if.out_ready = 1'b0;
    run_restoring(8'd50, 8'd6);
    commit_push(expected(8'd50, 8'd6));
    do_load(8'd33, 8'd4);
    sel = SEL_ALU; shift = 1'b1; add = 1'b0;
    step();
    chk("mid_sign", sign, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", res_if.out_valid, 1'b0);
    chk("async_sign", sign, 1'b0);
    chk("async_overrun", overrun, 1'b0);
    chk("async_quotient", res_if.quotient, '0);
    chk("async_remainder", res_if.remainder, '0);
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
    chk("async_dz", dz, 1'b0);
`endif
    idle();
    step();
    reset = 1'b1;
    res_if.out_ready = 1'b1;
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_datapath.md
Name: divider_datapath

Overview:
- Arithmetic datapath for the shift/add-subtract divider. Sits directly downstream of the divider controller and is driven by its load/sel/shift/inbit/add outputs.
- Holds divisor, remainder and quotient registers. Returns the remainder sign bit that the controller uses for its next decision.
- Captures each finished quotient/remainder pair into an output register with a valid/ready handshake toward the consumer.

Parameters:
- WIDTH, 8, operand width in bits for the dividend, the divisor and the quotient; the remainder register is WIDTH+1 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state)
- dividend  in  WIDTH  unsigned dividend, sampled on load
- divisor  in  WIDTH  unsigned divisor, sampled on load
- load  in  1  controller: initialise registers
- sel  in  2  controller: remainder-update select
- shift  in  1  controller: shift {R,Q} left by one
- inbit  in  1  controller: bit shifted into Q[0]
- add  in  1  controller: 1 = R+D, 0 = R-D
- sign  out  1  R[WIDTH], the remainder sign, driven from a register
- quotient  out  WIDTH  captured quotient
- remainder  out  WIDTH  captured, corrected remainder
- out_valid  out  1  result held and available
- out_ready  in  1  consumer accepts the result
- overrun  out  1  sticky: a result was overwritten before it was accepted

Behaviour:
- Reset (reset=0, asynchronous): D, Q, R, quotient, remainder, out_valid and overrun all go to 0, so sign=0.
- Working registers: D[WIDTH-1:0], Q[WIDTH-1:0], R[WIDTH:0] (two's complement).
- Priority per rising edge: load > arithmetic/shift.
  - load=1: D<=divisor, Q<=dividend, R<=0. All other controls are ignored that cycle.
  - shift=1, sel!=01: {R,Q} <= {R[WIDTH-1:0],Q,inbit}, so R drops its old MSB.
  - sel=01, shift=0: R <= R+{0,D} if add, else R-{0,D}, modulo 2^(WIDTH+1).
  - sel=01, shift=1 (combined non-restoring step): R <= shifted R ± D; Q <= {Q[WIDTH-2:0],inbit}.
  - sel=10: idle; hold all working registers.
  - sel=00: hold all working registers.
  - sel=11 (commit), working registers unchanged:
    - quotient <= Q.
    - remainder <= (R[WIDTH] ? R+D : R)[WIDTH-1:0], i.e. the final restore.
    - out_valid <= 1.
- Output handshake:
  - out_valid clears on a rising edge with out_ready=1, unless a commit happens in the same cycle; then out_valid stays 1 and the new data is loaded.
  - Commit while out_valid=1 and out_ready=0: data is overwritten and overrun <= 1.
  - overrun clears only on reset.
- Latency:
  - sign reflects the R update on the edge after the control is applied.
  - Result is visible one cycle after sel=11.
- Reset mid-division: everything clears immediately and any pending result is lost.
- Divisor 0 without the optional feature: arithmetic proceeds unchanged, giving quotient all-ones and remainder = dividend for a restoring sequence.

Optional Feature:
- Macro: DIVIDER_DIV_ZERO_DETECT_EN.
- Defined:
  - Adds output dz (1 bit). dz <= (divisor==0) on load; it is held otherwise and reset to 0.
  - On a commit with dz=1, quotient and remainder are forced to 0 and out_valid is still asserted.
- Undefined: no dz port, no forcing.

Decomposition:
- Shared package divider_pkg holds:
  - SEL_HOLD=2'b00, SEL_ALU=2'b01, SEL_IDLE=2'b10, SEL_COMMIT=2'b11;
  - default WIDTH.
  The controller uses the same package.
- One sub-module, divider_addsub: a (WIDTH+1)-bit combinational adder/subtractor with inputs a, b and add, and output sum. It is used for both the ALU step and the commit correction (two instances).

Test Plan:
- Reset: hold reset=0 with arbitrary inputs, then release -> all outputs 0, and sign=0 on the first edge.
- Restoring sequence: load 100/7 (WIDTH=8), then 8 iterations of shift, subtract and conditional restore, then commit -> quotient=14, remainder=2, out_valid=1.
- Combined step and sign: after load 5/3 and shift with sel=01, add=0 -> R=0-3 → sign=1. Then sel=01, add=1 -> sign=0.
- Handshake: commit with out_ready=0 -> out_valid held across 3 cycles. Then out_ready=1 -> out_valid=0 next edge. A second commit before acceptance -> overrun=1 and the new data is shown.
- Simultaneous events: commit and out_ready=1 in the same cycle -> out_valid stays 1 and the new data appears. load together with sel=01 -> only the load takes effect.
- Optional (macro defined): load 200/0 then commit -> dz=1, quotient=0, remainder=0, out_valid=1. Reset asserted mid-sequence -> immediate clear.
